// File: rtl/fetch_pc_redirect.sv
// rtl/fetch_pc_redirect.sv - fetch PC register with execute-stage redirect, stall parking and wrong-path flush
module fetch_pc_redirect #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_in,
    input  logic        branch_taken_in,
    input  logic [31:0] branch_target_in,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4_out,
    output logic        inst_valid_out,
    output logic        flush_out,
    output logic        misalign_out,
    output logic [31:0] bad_addr_out
);
    typedef enum logic [1:0] {RUN, PEND, FLUSH} state_t;

    localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_CYCLES);

    state_t      state, state_nx;
    logic [31:0] pc, pc_nx;
    logic [31:0] pend, pend_nx;
    logic [31:0] bad, bad_nx;
    logic [1:0]  cnt, cnt_nx;
    logic        mis, mis_nx;
    logic        redirect;
    logic [31:0] redir_tgt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            pc    <= RESET_PC;
            pend  <= 32'h0;
            bad   <= 32'h0;
            cnt   <= 2'd0;
            mis   <= 1'b0;
        end else begin
            state <= state_nx;
            pc    <= pc_nx;
            pend  <= pend_nx;
            bad   <= bad_nx;
            cnt   <= cnt_nx;
            mis   <= mis_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        pc_nx     = pc;
        pend_nx   = pend;
        bad_nx    = bad;
        cnt_nx    = cnt;
        mis_nx    = 1'b0;
        redirect  = 1'b0;
        redir_tgt = pend;
        case (state)
            RUN: begin
                if (branch_taken_in && !stall_in) begin
                    redirect  = 1'b1;
                    redir_tgt = branch_target_in;
                end else if (branch_taken_in) begin
                    pend_nx  = branch_target_in;
                    state_nx = PEND;
                end else if (!stall_in) begin
                    pc_nx = pc_plus4_out;
                end
            end
            PEND: begin
                // Younger branches here come from the shadow of the parked one
                if (!stall_in) begin
                    redirect  = 1'b1;
                    redir_tgt = pend;
                end
            end
            FLUSH: begin
                if (!stall_in) begin
                    pc_nx  = pc_plus4_out;
                    cnt_nx = cnt - 2'd1;
                    if (cnt == 2'd1) state_nx = RUN;
                end
            end
            default: state_nx = RUN;
        endcase
        if (redirect) begin
            cnt_nx   = FLUSH_INIT;
            state_nx = FLUSH;
            if (redir_tgt[1:0] == 2'b00) begin
                pc_nx = redir_tgt;
            end else begin
                pc_nx  = EXC_VECTOR;
                bad_nx = redir_tgt;
                mis_nx = 1'b1;
            end
        end
    end

    assign pc_out         = pc;
    assign pc_plus4_out   = pc + 32'd4;
    assign flush_out      = (state == FLUSH);
    assign inst_valid_out = (state == RUN) & ~stall_in & ~rst;
    assign misalign_out   = mis;
    assign bad_addr_out   = bad;
endmodule

// File: tb/tb_fetch_pc_redirect.sv
// tb/tb_fetch_pc_redirect.sv - scoreboard bench for fetch_pc_redirect
module tb_fetch_pc_redirect;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_in = 1'b0;
    logic        branch_taken_in = 1'b0;
    logic [31:0] branch_target_in = 32'h0;
    logic [31:0] pc_out, pc_plus4_out, bad_addr_out;
    logic        inst_valid_out, flush_out, misalign_out;
    logic [31:0] pc2_out, pc2_plus4_out, bad2_addr_out;
    logic        inst2_valid_out, flush2_out, misalign2_out;
    logic        zero_bit = 1'b0;
    logic [31:0] zero_word = 32'h0;

    int errors = 0;
    int checks = 0;
    bit driver_done = 1'b0;

    typedef struct packed {
        logic [31:0] pc;
        logic        fl;
        logic        val;
        logic        mis;
        logic [31:0] bad;
        logic        c2;
        logic [31:0] pc2;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    fetch_pc_redirect dut (
        .clk(clk), .rst(rst), .stall_in(stall_in),
        .branch_taken_in(branch_taken_in), .branch_target_in(branch_target_in),
        .pc_out(pc_out), .pc_plus4_out(pc_plus4_out), .inst_valid_out(inst_valid_out),
        .flush_out(flush_out), .misalign_out(misalign_out), .bad_addr_out(bad_addr_out)
    );

    fetch_pc_redirect #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .rst(rst), .stall_in(zero_bit),
        .branch_taken_in(zero_bit), .branch_target_in(zero_word),
        .pc_out(pc2_out), .pc_plus4_out(pc2_plus4_out), .inst_valid_out(inst2_valid_out),
        .flush_out(flush2_out), .misalign_out(misalign2_out), .bad_addr_out(bad2_addr_out)
    );

    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endfunction

    // Drive this cycle's inputs and queue what the DUT must show before the next edge
    task automatic row(input logic r, input logic s, input logic b, input logic [31:0] t,
                       input logic [31:0] e_pc, input logic e_fl, input logic e_val,
                       input logic e_mis, input logic [31:0] e_bad,
                       input logic e_c2, input logic [31:0] e_pc2);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r;
        stall_in = s;
        branch_taken_in = b;
        branch_target_in = t;
        e.pc = e_pc; e.fl = e_fl; e.val = e_val; e.mis = e_mis;
        e.bad = e_bad; e.c2 = e_c2; e.pc2 = e_pc2;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("pc_out", pc_out, e.pc);
            chk("pc_plus4_out", pc_plus4_out, e.pc + 32'd4);
            chk("flush_out", {31'h0, flush_out}, {31'h0, e.fl});
            chk("inst_valid_out", {31'h0, inst_valid_out}, {31'h0, e.val});
            chk("misalign_out", {31'h0, misalign_out}, {31'h0, e.mis});
            chk("bad_addr_out", bad_addr_out, e.bad);
            if (e.c2) begin
                chk("wrap_pc_out", pc2_out, e.pc2);
                chk("wrap_pc_plus4_out", pc2_plus4_out, e.pc2 + 32'd4);
            end
        end
    end

    initial begin
        //   rst  stl  br   target        pc            fl   val  mis  bad           c2   pc2
        row(1'b1,1'b0,1'b0,32'h0,        32'h0,        1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0);
        row(1'b0,1'b0,1'b0,32'h0,        32'h0,        1'b0,1'b1,1'b0,32'h0,        1'b0,32'h0);
        row(1'b0,1'b0,1'b0,32'h0,        32'h4,        1'b0,1'b1,1'b0,32'h0,        1'b0,32'h0);
        row(1'b0,1'b0,1'b0,32'h0,        32'h8,        1'b0,1'b1,1'b0,32'h0,        1'b0,32'h0);
        row(1'b0,1'b0,1'b0,32'h0,        32'hC,        1'b0,1'b1,1'b0,32'h0,        1'b0,32'h0);
        // taken branch at 0x10 to 0x40, two flush cycles
        row(1'b0,1'b0,1'b1,32'h40,       32'h10,       1'b0,1'b1,1'b0,32'h0,        1'b0,32'h0);
        row(1'b0,1'b0,1'b0,32'h0,        32'h40,       1'b1,1'b0,1'b0,32'h0,        1'b0,32'h0);
        row(1'b0,1'b0,1'b0,32'h0,        32'h44,       1'b1,1'b0,1'b0,32'h0,        1'b0,32'h0);
        // branch under stall parks; second branch while parked is dropped
        row(1'b0,1'b1,1'b1,32'h100,      32'h48,       1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0);
        row(1'b0,1'b1,1'b1,32'h200,      32'h48,       1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0);
        row(1'b0,1'b1,1'b0,32'h0,        32'h48,       1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0);
        row(1'b0,1'b0,1'b0,32'h0,        32'h48,       1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0);
        row(1'b0,1'b0,1'b0,32'h0,        32'h100,      1'b1,1'b0,1'b0,32'h0,        1'b0,32'h0);
        row(1'b0,1'b0,1'b0,32'h0,        32'h104,      1'b1,1'b0,1'b0,32'h0,        1'b0,32'h0);
        // misaligned target vectors to 0x80; stall pulse stretches the flush
        row(1'b0,1'b0,1'b1,32'h122,      32'h108,      1'b0,1'b1,1'b0,32'h0,        1'b0,32'h0);
        row(1'b0,1'b0,1'b0,32'h0,        32'h80,       1'b1,1'b0,1'b1,32'h122,      1'b0,32'h0);
        row(1'b0,1'b1,1'b0,32'h0,        32'h84,       1'b1,1'b0,1'b0,32'h122,      1'b0,32'h0);
        row(1'b0,1'b0,1'b0,32'h0,        32'h84,       1'b1,1'b0,1'b0,32'h122,      1'b0,32'h0);
        row(1'b0,1'b0,1'b1,32'h40,       32'h88,       1'b0,1'b1,1'b0,32'h122,      1'b0,32'h0);
        row(1'b0,1'b0,1'b0,32'h0,        32'h40,       1'b1,1'b0,1'b0,32'h122,      1'b0,32'h0);
        // reset raised between edges at pc 0x44 must take effect before the next edge
        row(1'b1,1'b0,1'b0,32'h0,        32'h0,        1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0);
        row(1'b1,1'b0,1'b0,32'h0,        32'h0,        1'b0,1'b0,1'b0,32'h0,        1'b1,32'hFFFF_FFF8);
        row(1'b0,1'b0,1'b0,32'h0,        32'h0,        1'b0,1'b1,1'b0,32'h0,        1'b1,32'hFFFF_FFF8);
        row(1'b0,1'b0,1'b0,32'h0,        32'h4,        1'b0,1'b1,1'b0,32'h0,        1'b1,32'hFFFF_FFFC);
        row(1'b0,1'b0,1'b0,32'h0,        32'h8,        1'b0,1'b1,1'b0,32'h0,        1'b1,32'h0);
        driver_done = 1'b1;
    end

    initial begin
        int waited;
        waited = 0;
        while (!(driver_done && exp_q.size() == 0) && waited < 1000) begin
            @(posedge clk);
            waited++;
        end
        @(posedge clk);
        checks++;
        if (exp_q.size() != 0 || !driver_done) begin
            errors++;
            $display("FAIL drain: pending %0d expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
